// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm countdown block.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    localparam int unsigned DEF_TICK_DIV    = 50_000_000;
    localparam int unsigned DEF_COUNT_START = 9;
    localparam int unsigned DEF_SNOOZE_SEC  = 5;
    localparam int unsigned DIGIT_W         = 4;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles, restarted by clr.
module tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;
    logic             wrap;

    assign wrap = (count == CNT_W'(TICK_DIV - 1));
    assign tick = en && wrap;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alarm_countdown.sv
// Alarm countdown: on TRIGGER counts COUNT_START..0 at one step per tick, pulses EXPIRED.
// Optional snooze state is built only when ALARM_SNOOZE_EN is defined.
module alarm_countdown
    import alarm_pkg::*;
#(
    parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
    parameter int unsigned COUNT_START = DEF_COUNT_START,
    parameter int unsigned SNOOZE_SEC  = DEF_SNOOZE_SEC
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               TRIGGER,
    input  logic               DISMISS,
    input  logic               SNOOZE,
    output logic               ALARM,
    output logic [DIGIT_W-1:0] digit,
    output logic               EXPIRED
);

    localparam logic [DIGIT_W-1:0] START_DIGIT = DIGIT_W'(COUNT_START);

    state_t             state;
    state_t             state_next;
    logic               tick;
    logic               presc_clr;
    logic               presc_en;
    logic               alarm_next;
    logic [DIGIT_W-1:0] digit_next;
    logic               expired_next;

`ifdef ALARM_SNOOZE_EN
    localparam int unsigned SNZ_W = $clog2(SNOOZE_SEC + 1);

    logic [SNZ_W-1:0] snz_cnt;
    logic             snz_done;

    assign snz_done = tick && (snz_cnt == SNZ_W'(SNOOZE_SEC - 1));

    // Snooze tick counter, held at zero outside SNOOZED so every entry starts fresh
    always_ff @(posedge CLK) begin
        if (RST) begin
            snz_cnt <= '0;
        end else if (state != SNOOZED) begin
            snz_cnt <= '0;
        end else if (tick) begin
            snz_cnt <= snz_cnt + SNZ_W'(1);
        end
    end
`else
    localparam int unsigned unused_snooze_sec = SNOOZE_SEC;
    logic unused_snooze;
    assign unused_snooze = SNOOZE;
`endif

    // Prescaler restarts on every state change so the first tick lands TICK_DIV cycles in
    assign presc_en  = (state != IDLE);
    assign presc_clr = (state_next != state);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            ALARM   <= 1'b0;
            digit   <= '0;
            EXPIRED <= 1'b0;
        end else begin
            state   <= state_next;
            ALARM   <= alarm_next;
            digit   <= digit_next;
            EXPIRED <= expired_next;
        end
    end

    // Next state: DISMISS > SNOOZE > tick > TRIGGER
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (TRIGGER) state_next = COUNT;
            end
            COUNT: begin
                if (DISMISS) begin
                    state_next = IDLE;
                end
`ifdef ALARM_SNOOZE_EN
                else if (SNOOZE) begin
                    state_next = SNOOZED;
                end
`endif
                else if (tick && (digit == '0)) begin
                    state_next = IDLE;
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZED: begin
                if (DISMISS) begin
                    state_next = IDLE;
                end else if (snz_done) begin
                    state_next = COUNT;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        alarm_next   = ALARM;
        digit_next   = digit;
        expired_next = 1'b0;
        case (state)
            IDLE: begin
                alarm_next = TRIGGER;
                digit_next = TRIGGER ? START_DIGIT : '0;
            end
            COUNT: begin
                if (DISMISS) begin
                    alarm_next = 1'b0;
                    digit_next = '0;
                end
`ifdef ALARM_SNOOZE_EN
                else if (SNOOZE) begin
                    alarm_next = 1'b0;
                    digit_next = '0;
                end
`endif
                else if (tick) begin
                    if (digit == '0) begin
                        alarm_next   = 1'b0;
                        expired_next = 1'b1;
                    end else begin
                        digit_next = digit - DIGIT_W'(1);
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZED: begin
                if (!DISMISS && snz_done) begin
                    alarm_next = 1'b1;
                    digit_next = START_DIGIT;
                end else begin
                    alarm_next = 1'b0;
                    digit_next = '0;
                end
            end
`endif
            default: begin
                alarm_next = 1'b0;
                digit_next = '0;
            end
        endcase
    end

endmodule
